// File: rtl/ddr_rd_port_arb_if.sv
// Request/descriptor bundle for ddr_rd_port_arb.
// master = requesting ports plus DDR read engine, slave = the arbiter.
interface ddr_rd_port_arb_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned P_PORT_NUM         = 4,
    parameter int unsigned P_DDR_LOCAL_QUEUE  = 4
);
    localparam int unsigned PW = $clog2(P_PORT_NUM);

    logic [P_PORT_NUM*P_DDR_LOCAL_QUEUE-1:0]  i_req_queue;
    logic [P_PORT_NUM*C_M_AXI_ADDR_WIDTH-1:0] i_req_byte;
    logic [P_PORT_NUM-1:0]                    i_req_valid;
    logic [P_PORT_NUM-1:0]                    o_req_ready;
    logic [PW-1:0]                            o_rd_port;
    logic [P_DDR_LOCAL_QUEUE-1:0]             o_rd_queue;
    logic [C_M_AXI_ADDR_WIDTH-1:0]            o_rd_byte;
    logic                                     o_rd_last;
    logic                                     o_rd_valid;
    logic                                     i_rd_ready;
    logic                                     i_rd_finish;
    logic [P_PORT_NUM-1:0]                    o_port_busy;

    modport master (
        output i_req_queue, i_req_byte, i_req_valid, i_rd_ready, i_rd_finish,
        input  o_req_ready, o_rd_port, o_rd_queue, o_rd_byte, o_rd_last, o_rd_valid,
               o_port_busy
    );

    modport slave (
        input  i_req_queue, i_req_byte, i_req_valid, i_rd_ready, i_rd_finish,
        output o_req_ready, o_rd_port, o_rd_queue, o_rd_byte, o_rd_last, o_rd_valid,
               o_port_busy
    );
endinterface

// File: rtl/ddr_rd_port_arb.sv
// Round-robin arbiter turning per-port read requests into DDR read descriptors, one in flight.
// Define DDR_RD_SPLIT_EN to split each request into chunks of at most P_MAX_BURST_BYTE.
module ddr_rd_port_arb #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned P_PORT_NUM         = 4,
    parameter int unsigned P_DDR_LOCAL_QUEUE  = 4,
    parameter int unsigned P_REQ_FIFO_DEPTH   = 4,
    parameter int unsigned P_MAX_BURST_BYTE   = 4096
) (
    input logic              i_clk,
    input logic              i_rst,
    ddr_rd_port_arb_if.slave bus
);
    localparam int unsigned PW = $clog2(P_PORT_NUM);
    localparam int unsigned AW = $clog2(P_REQ_FIFO_DEPTH);
    localparam int unsigned QW = P_DDR_LOCAL_QUEUE;
    localparam int unsigned BW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StPop, StIssue, StWait} state_e;

    // Per-port request FIFOs
    logic [QW-1:0] q_mem    [P_PORT_NUM][P_REQ_FIFO_DEPTH];
    logic [BW-1:0] b_mem    [P_PORT_NUM][P_REQ_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [P_PORT_NUM];
    logic [AW-1:0] rd_ptr_q [P_PORT_NUM];
    logic [AW:0]   cnt_q    [P_PORT_NUM];

    logic [P_PORT_NUM-1:0] push;
    logic [P_PORT_NUM-1:0] pop;
    logic [P_PORT_NUM-1:0] full;
    logic [P_PORT_NUM-1:0] nonempty;

    // Arbitration / working registers
    state_e                state_q, state_d;
    logic [PW-1:0]         port_q, port_d;
    logic [QW-1:0]         queue_q, queue_d;
    logic [BW-1:0]         rem_q, rem_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [P_PORT_NUM-1:0] busy_q, busy_d;

    logic                  sel_found;
    logic [PW-1:0]         sel_port;
    logic [PW-1:0]         next_port;
    logic [QW-1:0]         head_queue;
    logic [BW-1:0]         head_byte;
    logic [BW-1:0]         chunk_byte;
    logic                  chunk_last;

    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        pop      = '0;
        for (int p = 0; p < P_PORT_NUM; p++) begin
            full[p]     = (cnt_q[p] == (AW+1)'(P_REQ_FIFO_DEPTH));
            nonempty[p] = (cnt_q[p] != '0);
            push[p]     = bus.i_req_valid[p] & ~full[p] & ~i_rst;
            pop[p]      = (state_q == StPop) && (port_q == PW'(p));
        end
    end

    // Ready comes from the registered count, so a same-cycle pop cannot raise it.
    assign bus.o_req_ready = ~full & {P_PORT_NUM{~i_rst}};

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < P_PORT_NUM; p++) begin
            if (push[p]) begin
                q_mem[p][wr_ptr_q[p]] <= bus.i_req_queue[p*QW +: QW];
                b_mem[p][wr_ptr_q[p]] <= bus.i_req_byte[p*BW +: BW];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int p = 0; p < P_PORT_NUM; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < P_PORT_NUM; p++) begin
                if (push[p]) begin
                    wr_ptr_q[p] <= wr_ptr_q[p] + AW'(1);
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + AW'(1);
                end
                cnt_q[p] <= cnt_q[p] + {{AW{1'b0}}, push[p]} - {{AW{1'b0}}, pop[p]};
            end
        end
    end

    // First non-empty port searching upward from rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_port  = '0;
        for (int unsigned i = 0; i < P_PORT_NUM; i++) begin
            idx = (int'(rr_ptr_q) + i) % P_PORT_NUM;
            if (!sel_found && nonempty[idx]) begin
                sel_found = 1'b1;
                sel_port  = PW'(idx);
            end
        end
    end

    assign next_port  = (port_q == PW'(P_PORT_NUM - 1)) ? '0 : port_q + PW'(1);
    assign head_queue = q_mem[port_q][rd_ptr_q[port_q]];
    assign head_byte  = b_mem[port_q][rd_ptr_q[port_q]];

`ifdef DDR_RD_SPLIT_EN
    always_comb begin
        chunk_last = (rem_q <= BW'(P_MAX_BURST_BYTE));
        chunk_byte = chunk_last ? rem_q : BW'(P_MAX_BURST_BYTE);
    end
`else
    always_comb begin
        chunk_last = 1'b1;
        chunk_byte = rem_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        queue_d  = queue_q;
        rem_d    = rem_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    port_d  = sel_port;
                    state_d = StPop;
                end
            end
            StPop: begin
                queue_d = head_queue;
                rem_d   = head_byte;
                if (head_byte != '0) begin
                    busy_d[port_q] = 1'b1;
                    state_d        = StIssue;
                end else begin
                    // Zero-byte request: dropped without a descriptor.
                    rr_ptr_d = next_port;
                    state_d  = StIdle;
                end
            end
            StIssue: begin
                if (bus.i_rd_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.i_rd_finish) begin
                    // chunk_byte never exceeds rem_q, so this cannot underflow.
                    rem_d = rem_q - chunk_byte;
                    if (chunk_last) begin
                        busy_d[port_q] = 1'b0;
                        rr_ptr_d       = next_port;
                        state_d        = StIdle;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            port_q   <= '0;
            queue_q  <= '0;
            rem_q    <= '0;
            rr_ptr_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            queue_q  <= queue_d;
            rem_q    <= rem_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_rd_valid  = (state_q == StIssue);
    assign bus.o_rd_last   = (state_q == StIssue) & chunk_last;
    assign bus.o_rd_port   = port_q;
    assign bus.o_rd_queue  = queue_q;
    assign bus.o_rd_byte   = chunk_byte;
    assign bus.o_port_busy = busy_q;
endmodule

// File: doc/ddr_rd_port_arb.md
DDR_RD_PORT_ARB -- requirements
Module: ddr_rd_port_arb

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, setting the width of the byte-count field.
REQ-002 The block SHALL have parameter P_PORT_NUM, default 4, setting the number of requesting ports; legal values are 2 to 16.
REQ-003 The block SHALL have parameter P_DDR_LOCAL_QUEUE, default 4, setting the width of the queue-id field.
REQ-004 The block SHALL have parameter P_REQ_FIFO_DEPTH, default 4, setting the per-port request FIFO depth; legal values are powers of two, 2 or greater.
REQ-005 The block SHALL have parameter P_MAX_BURST_BYTE, default 4096, setting the largest byte count in one issued descriptor.
REQ-006 The block SHALL use the local width PW = $clog2(P_PORT_NUM).
REQ-007 Clock and reset: the block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-008 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-009 i_rst  in  1  asynchronous, active-high reset.
REQ-010 i_req_queue  in  P_PORT_NUM*P_DDR_LOCAL_QUEUE  per-port queue id; port p occupies slice p.
REQ-011 i_req_byte  in  P_PORT_NUM*C_M_AXI_ADDR_WIDTH  per-port read byte count.
REQ-012 i_req_valid  in  P_PORT_NUM  per-port request valid.
REQ-013 o_req_ready  out  P_PORT_NUM  per-port FIFO not full.
REQ-014 o_rd_port  out  PW  port that owns the current descriptor.
REQ-015 o_rd_queue  out  P_DDR_LOCAL_QUEUE  queue id of the current descriptor.
REQ-016 o_rd_byte  out  C_M_AXI_ADDR_WIDTH  byte count of the current chunk.
REQ-017 o_rd_last  out  1  current chunk is the final chunk of its request.
REQ-018 o_rd_valid  out  1  descriptor valid.
REQ-019 i_rd_ready  in  1  DDR read engine accepts the descriptor.
REQ-020 i_rd_finish  in  1  one-cycle pulse: the accepted chunk has been fully read.
REQ-021 o_port_busy  out  P_PORT_NUM  bit p is high from the pop of port p's request until its last chunk finishes.

Function
REQ-022 A push into FIFO p SHALL occur when i_req_valid[p] and o_req_ready[p] are both high.
REQ-023 o_req_ready[p] SHALL be low exactly when FIFO p holds P_REQ_FIFO_DEPTH entries; a pop in the same cycle SHALL NOT raise ready in that cycle.
REQ-024 The FSM SHALL have four states: IDLE, POP, ISSUE and WAIT.
REQ-025 In IDLE, if any FIFO is non-empty, the FSM SHALL select the first non-empty port searching upward from rr_ptr (wrapping modulo P_PORT_NUM) and go to POP; otherwise it SHALL stay in IDLE.
REQ-026 In POP, the head entry SHALL be popped into working registers (port, queue, rem_byte).
REQ-027 In POP, if rem_byte is nonzero, the FSM SHALL go to ISSUE and set o_port_busy for that port.
REQ-028 In POP, if rem_byte is 0, the entry SHALL be discarded with no descriptor, rr_ptr SHALL become port+1 (wrapping P_PORT_NUM-1 to 0), and the FSM SHALL return to IDLE.
REQ-029 In ISSUE, o_rd_valid SHALL be 1, o_rd_byte SHALL be min(rem_byte, P_MAX_BURST_BYTE), and o_rd_last SHALL be 1 exactly when rem_byte <= P_MAX_BURST_BYTE.
REQ-030 All descriptor outputs SHALL be held stable until the cycle in which i_rd_ready is 1, after which the FSM SHALL go to WAIT.
REQ-031 In WAIT, on i_rd_finish, rem_byte SHALL be decremented by o_rd_byte; if the chunk was last, the FSM SHALL clear o_port_busy, set rr_ptr to port+1 (wrapping) and go to IDLE, otherwise it SHALL return to ISSUE.
REQ-032 i_rd_finish SHALL be ignored outside WAIT, and i_rd_ready SHALL be ignored outside ISSUE.
REQ-033 Latency: a push into an empty block at cycle N SHALL give o_rd_valid high at cycle N+3 (N+1 IDLE select, N+2 POP, N+3 ISSUE).
REQ-034 The block SHALL have exactly one request in flight at any time; other ports SHALL keep accepting pushes meanwhile.
REQ-035 Byte arithmetic SHALL be unsigned at C_M_AXI_ADDR_WIDTH; rem_byte SHALL never underflow.

Reset
REQ-036 While i_rst is high, the FSM SHALL be IDLE, all FIFOs SHALL be empty, rr_ptr SHALL be 0, and o_rd_valid, o_rd_last, o_rd_port, o_rd_queue, o_rd_byte and o_port_busy SHALL be 0.
REQ-037 While i_rst is high, o_req_ready SHALL be forced to 0; it SHALL become all ones in the first cycle after deassertion.
REQ-038 Reset asserted mid-request SHALL abandon the request, with no completion reported.

Configuration
REQ-039 The macro DDR_RD_SPLIT_EN SHALL control chunk splitting.
REQ-040 With DDR_RD_SPLIT_EN defined, chunk splitting SHALL follow REQ-029 to REQ-031.
REQ-041 Without DDR_RD_SPLIT_EN, o_rd_byte SHALL equal the full rem_byte, o_rd_last SHALL be tied to 1, the first i_rd_finish SHALL return the FSM to IDLE, and P_MAX_BURST_BYTE SHALL be unused.

Verification
REQ-042 Scenario 1: port 1 pushes queue 3, 1000 bytes, with i_rd_ready held high -> one descriptor with o_rd_port=1, o_rd_queue=3, o_rd_byte=1000 and o_rd_last=1, with o_rd_valid high 3 cycles after the push.
REQ-043 Scenario 2 (DDR_RD_SPLIT_EN): port 0 pushes 10000 bytes -> chunks 4096, 4096, 1808, with o_rd_last only on 1808, and no descriptor before each i_rd_finish.
REQ-044 Scenario 3: all 4 ports push 64 bytes in the same cycle after reset -> grant order 0, 1, 2, 3; a further push on port 0 during port 3's request -> port 0 is granted next, after rr_ptr wraps to 0.
REQ-045 Scenario 4: 5 pushes to port 2 with no pops -> o_req_ready[2] falls after the 4th push, and the 5th is held off until a pop.
REQ-046 Scenario 5: port 3 pushes 0 bytes, then port 0 pushes 64 bytes -> no descriptor for port 3, then port 0 is served.
REQ-047 Scenario 6: i_rst is pulsed while in WAIT with 2 chunks pending -> all outputs are 0 immediately, and a new request after reset is served normally.
